rtc_bus_ctrl: RTL and testbench
===============================

Name: rtc_bus_ctrl

Overview:
Downstream of the port-ID decoder. Consumes the decoder's RTC enable and 8-bit RTC register address, plus the processor write/read strobes and output data. Runs one complete multiplexed address/data bus cycle to the external RTC chip (address phase, then data phase), and returns read data to the processor input mux. Provides busy/done status for the controlling firmware.

Parameters:
PHASE_CYC, 10, clock cycles per bus phase (100 ns at 100 MHz); legal range 1..255

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
act_rtc  in  1  RTC select from port-ID decoder
dir  in  8  RTC register address from decoder
wr_strobe  in  1  processor write strobe, 1-cycle pulse
rd_strobe  in  1  processor read strobe, 1-cycle pulse
data_in  in  8  processor out_port data
ad_in  in  8  RTC AD bus input (external tristate pad)
ad_out  out  8  RTC AD bus drive value
ad_oe  out  1  AD bus output enable (1 = drive)
cs_n  out  1  RTC chip select, active low
a_d  out  1  0 = address phase, 1 = data phase
wr_n  out  1  RTC write strobe, active low
rd_n  out  1  RTC read strobe, active low
data_out  out  8  last read byte, to processor in_port mux
busy  out  1  transaction in progress
done  out  1  1-cycle pulse at end of transaction

Behaviour:
- Reset (sync, active-high): state IDLE, phase counter 0, ad_out=0, ad_oe=0, cs_n=1, a_d=0, wr_n=1, rd_n=1, data_out=0, busy=0, done=0. Reset mid-transaction aborts on that edge; the bus returns to idle levels and no done pulse is issued.
- Accept: in IDLE, act_rtc=1 with wr_strobe or rd_strobe at the edge (cycle 0). On accept, latch dir, data_in and op (write if wr_strobe=1; write wins if both strobes are high). Strobes without act_rtc are ignored.
- States (each non-IDLE phase lasts exactly PHASE_CYC cycles; counter counts 0..PHASE_CYC-1, then advances):
  ADDR_LO: cs_n=0, a_d=0, wr_n=0, ad_oe=1, ad_out=latched dir
  ADDR_HI: cs_n=0, a_d=0, wr_n=1, ad_oe=1, address held
  GAP: cs_n=1, ad_oe=0, all strobes high
  DATA_LO: cs_n=0, a_d=1. Write: wr_n=0, ad_oe=1, ad_out=latched data. Read: rd_n=0, ad_oe=0; ad_in sampled into data_out on the last cycle of the phase.
  DATA_HI: cs_n=0, a_d=1, strobes high. Write keeps ad_oe=1 (data hold); read keeps ad_oe=0.
  DONE: one cycle, done=1, bus idle levels, then IDLE.
- Timing: ADDR_LO is entered at cycle 1. DONE occurs at cycle 5*PHASE_CYC+1. busy=1 from cycle 1 through DONE inclusive.
- Requests arriving while busy=1 are ignored; no queueing.
- data_out changes only on reads and holds its value otherwise. Writes never alter data_out.
- ad_oe and a read strobe are never both active in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
RTC_BCD_CONV_EN
- Defined: conversion applies only to time/date/timer addresses dir in 8'h21..8'h26 and 8'h41..8'h43.
  - Write data is converted binary to BCD at latch time; values >99 saturate to 8'h99.
  - Read data is converted BCD to binary (hi*10+lo) as it is captured into data_out.
  - All other addresses pass through unchanged.
- Undefined: all data passes through unchanged. Conversion logic is absent.

Test Plan:
- PHASE_CYC=2; write 8'h59 to dir 8'h21 (macro off) -> ADDR_LO cycles 1-2 show ad_out=8'h21, a_d=0, wr_n=0. DATA_LO cycles 7-8 show ad_out=8'h59, wr_n=0, a_d=1. done pulses at cycle 11 only. data_out stays 0.
- PHASE_CYC=2; read dir 8'hF0 with ad_in=8'h37 during DATA_LO -> rd_n=0 cycles 7-8, ad_oe=0 throughout the data phase, data_out=8'h37 after cycle 8, done at cycle 11.
- wr_strobe with act_rtc=0 -> no bus activity, busy stays 0. A second accepted-style request at cycle 4 of an active transaction -> ignored, exactly one done pulse.
- reset asserted at cycle 5 of a write -> next edge cs_n=1, ad_oe=0, busy=0, no done. A new request afterwards completes normally.
- wr_strobe and rd_strobe together with act_rtc=1 -> write cycle executed, rd_n never low.
- RTC_BCD_CONV_EN defined: write 8'd45 to dir 8'h22 -> bus data 8'h45. Read dir 8'h41 with ad_in=8'h45 -> data_out=8'd45. Read dir 8'h02 with ad_in=8'h45 -> data_out=8'h45.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data bus sequencer for the external RTC chip: one address
// phase, a bus-turnaround gap, one data phase. Optional macro: RTC_BCD_CONV_EN.
module rtc_bus_ctrl #(
  parameter int PHASE_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       act_rtc,
  input  logic [7:0] dir,
  input  logic       wr_strobe,
  input  logic       rd_strobe,
  input  logic [7:0] data_in,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       a_d,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LAST_CNT = 8'(PHASE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_LO = 3'd1,
    S_ADDR_HI = 3'd2,
    S_GAP     = 3'd3,
    S_DATA_LO = 3'd4,
    S_DATA_HI = 3'd5,
    S_DONE    = 3'd6
  } state_t;

`ifdef RTC_BCD_CONV_EN
  function automatic logic is_bcd_addr(input logic [7:0] a);
    return ((a >= 8'h21) && (a <= 8'h26)) || ((a >= 8'h41) && (a <= 8'h43));
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    logic [7:0] tens;
    logic [7:0] ones;
    if (v > 8'd99) begin
      return 8'h99;
    end else begin
      tens = v / 8'd10;
      ones = v - (tens * 8'd10);
      return {tens[3:0], ones[3:0]};
    end
  endfunction

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
    return ({4'h0, v[7:4]} * 8'd10) + {4'h0, v[3:0]};
  endfunction

  function automatic logic [7:0] conv_wr(input logic [7:0] a, input logic [7:0] d);
    if (is_bcd_addr(a)) begin
      return bin_to_bcd(d);
    end else begin
      return d;
    end
  endfunction

  function automatic logic [7:0] conv_rd(input logic [7:0] a, input logic [7:0] d);
    if (is_bcd_addr(a)) begin
      return bcd_to_bin(d);
    end else begin
      return d;
    end
  endfunction
`endif

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] addr_r, addr_s;
  logic [7:0] wdata_r, wdata_s;
  logic       op_wr_r, op_wr_s;
  logic       phase_end_s;

  logic [7:0] ad_out_r, ad_out_s;
  logic       ad_oe_r, ad_oe_s;
  logic       cs_n_r, cs_n_s;
  logic       a_d_r, a_d_s;
  logic       wr_n_r, wr_n_s;
  logic       rd_n_r, rd_n_s;
  logic [7:0] data_out_r, data_out_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;

  assign phase_end_s = (cnt_r == LAST_CNT);

  // Next state, phase counter, request latch and read capture
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    op_wr_s    = op_wr_r;
    data_out_s = data_out_r;
    case (state_r)
      S_IDLE: begin
        if (act_rtc && (wr_strobe || rd_strobe)) begin
          state_s = S_ADDR_LO;
          cnt_s   = 8'd0;
          addr_s  = dir;
          op_wr_s = wr_strobe;
`ifdef RTC_BCD_CONV_EN
          wdata_s = conv_wr(dir, data_in);
`else
          wdata_s = data_in;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ADDR_LO, S_ADDR_HI, S_GAP, S_DATA_HI: begin
        if (phase_end_s) begin
          cnt_s = 8'd0;
          case (state_r)
            S_ADDR_LO: state_s = S_ADDR_HI;
            S_ADDR_HI: state_s = S_GAP;
            S_GAP:     state_s = S_DATA_LO;
            S_DATA_HI: state_s = S_DONE;
            default:   state_s = S_IDLE;
          endcase
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_DATA_LO: begin
        if (phase_end_s) begin
          cnt_s   = 8'd0;
          state_s = S_DATA_HI;
          // The RTC drives valid data by the end of the read strobe window
          if (!op_wr_r) begin
`ifdef RTC_BCD_CONV_EN
            data_out_s = conv_rd(addr_r, ad_in);
`else
            data_out_s = ad_in;
`endif
          end else begin
            data_out_s = data_out_r;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        cnt_s   = 8'd0;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Bus levels decoded from the upcoming state so every output is a flop
  always_comb begin
    ad_out_s = 8'h00;
    ad_oe_s  = 1'b0;
    cs_n_s   = 1'b1;
    a_d_s    = 1'b0;
    wr_n_s   = 1'b1;
    rd_n_s   = 1'b1;
    busy_s   = (state_s != S_IDLE);
    done_s   = (state_s == S_DONE);
    case (state_s)
      S_ADDR_LO: begin
        cs_n_s   = 1'b0;
        wr_n_s   = 1'b0;
        ad_oe_s  = 1'b1;
        ad_out_s = addr_s;
      end
      S_ADDR_HI: begin
        cs_n_s   = 1'b0;
        ad_oe_s  = 1'b1;
        ad_out_s = addr_s;
      end
      S_DATA_LO: begin
        cs_n_s = 1'b0;
        a_d_s  = 1'b1;
        if (op_wr_s) begin
          wr_n_s   = 1'b0;
          ad_oe_s  = 1'b1;
          ad_out_s = wdata_s;
        end else begin
          rd_n_s  = 1'b0;
          ad_oe_s = 1'b0;
        end
      end
      S_DATA_HI: begin
        cs_n_s = 1'b0;
        a_d_s  = 1'b1;
        if (op_wr_s) begin
          ad_oe_s  = 1'b1;
          ad_out_s = wdata_s;
        end else begin
          ad_oe_s = 1'b0;
        end
      end
      S_IDLE, S_GAP, S_DONE: begin
        ad_oe_s = 1'b0;
      end
      default: begin
        ad_oe_s = 1'b0;
      end
    endcase
  end

  // State, latched request and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 8'd0;
      addr_r     <= 8'h00;
      wdata_r    <= 8'h00;
      op_wr_r    <= 1'b0;
      ad_out_r   <= 8'h00;
      ad_oe_r    <= 1'b0;
      cs_n_r     <= 1'b1;
      a_d_r      <= 1'b0;
      wr_n_r     <= 1'b1;
      rd_n_r     <= 1'b1;
      data_out_r <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      op_wr_r    <= op_wr_s;
      ad_out_r   <= ad_out_s;
      ad_oe_r    <= ad_oe_s;
      cs_n_r     <= cs_n_s;
      a_d_r      <= a_d_s;
      wr_n_r     <= wr_n_s;
      rd_n_r     <= rd_n_s;
      data_out_r <= data_out_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign ad_out   = ad_out_r;
  assign ad_oe    = ad_oe_r;
  assign cs_n     = cs_n_r;
  assign a_d      = a_d_r;
  assign wr_n     = wr_n_r;
  assign rd_n     = rd_n_r;
  assign data_out = data_out_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: the expected bus waveform is derived
// from the cycle index of each transaction (phase = (cycle-1)/PHASE_CYC).
module tb_rtc_bus_ctrl;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       act_rtc;
  logic [7:0] dir;
  logic       wr_strobe;
  logic       rd_strobe;
  logic [7:0] data_in;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       a_d;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_dout = 8'h00;

  rtc_bus_ctrl #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset(reset), .act_rtc(act_rtc), .dir(dir),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .data_in(data_in),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .a_d(a_d),
    .wr_n(wr_n), .rd_n(rd_n), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic bit bcd_region(input logic [7:0] a);
    int v;
    v = int'(a);
    return (v >= 33 && v <= 38) || (v >= 65 && v <= 67);
  endfunction

  // Value expected on the AD bus during the data phase of a write
  function automatic logic [7:0] bus_wdata(input logic [7:0] a, input logic [7:0] d);
    int v;
    v = int'(d);
`ifdef RTC_BCD_CONV_EN
    if (bcd_region(a)) begin
      if (v > 99) return 8'h99;
      return 8'((v / 10) * 16 + (v % 10));
    end
`endif
    return d;
  endfunction

  // Value expected in data_out after a read
  function automatic logic [7:0] rd_value(input logic [7:0] a, input logic [7:0] bus);
    int v;
    v = int'(bus);
`ifdef RTC_BCD_CONV_EN
    if (bcd_region(a)) return 8'((v / 16) * 10 + (v % 16));
`endif
    return bus;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    act_rtc   = 1'b0;
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    dir       = 8'($urandom);
    data_in   = 8'($urandom);
  endtask

  // One full transaction, checked every cycle; inj>0 injects a request at that cycle
  task automatic run_txn(input bit is_wr, input bit both, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] adin, input int inj);
    logic [5:0] ectl;
    logic [5:0] actl;
    logic       ead;
    logic [7:0] wv;
    int ph;
    wv = bus_wdata(a, d);
    act_rtc   = 1'b1;
    dir       = a;
    data_in   = d;
    wr_strobe = is_wr;
    rd_strobe = both | ~is_wr;
    ad_in     = 8'($urandom);
    next_cycle;
    idle_inputs;
    for (int k = 1; k <= 5 * P + 1; k++) begin
      ph = (k - 1) / P;
      ad_in = (ph == 3) ? adin : 8'($urandom);
      if (k == inj) begin
        act_rtc = 1'b1; wr_strobe = 1'b1; rd_strobe = 1'b1;
      end else begin
        act_rtc = 1'b0; wr_strobe = 1'b0; rd_strobe = 1'b0;
      end
      ead = 1'b0;
      if (k == 5 * P + 1) begin
        ectl = 6'b111011;
      end else begin
        case (ph)
          0: ectl = 6'b001110;
          1: ectl = 6'b011110;
          2: ectl = 6'b111010;
          3: begin ectl = is_wr ? 6'b001110 : 6'b010010; ead = 1'b1; end
          default: begin ectl = is_wr ? 6'b011110 : 6'b011010; ead = 1'b1; end
        endcase
      end
      if (!is_wr && k == 4 * P + 1) exp_dout = rd_value(a, adin);
      @(negedge clk);
      actl = {cs_n, wr_n, rd_n, ad_oe, busy, done};
      n_tests++;
      if (actl !== ectl) begin
        n_fail++;
        $display("FAIL txn_ctl cycle %0d wr=%0b: {cs_n,wr_n,rd_n,ad_oe,busy,done} got %b expected %b",
                 k, is_wr, actl, ectl);
      end
      if (ph != 2 || k == 5 * P + 1) begin
        n_tests++;
        if (a_d !== ead) begin
          n_fail++;
          $display("FAIL txn_a_d cycle %0d: got %b expected %b", k, a_d, ead);
        end
      end
      if (ectl[2]) begin
        n_tests++;
        if (ad_out !== ((ph < 2) ? a : wv)) begin
          n_fail++;
          $display("FAIL txn_ad_out cycle %0d: got %h expected %h", k, ad_out, (ph < 2) ? a : wv);
        end
      end
      n_tests++;
      if (data_out !== exp_dout) begin
        n_fail++;
        $display("FAIL txn_data_out cycle %0d: got %h expected %h", k, data_out, exp_dout);
      end
      next_cycle;
    end
    idle_inputs;
    @(negedge clk);
    n_tests++;
    if ({busy, done, cs_n, ad_oe} !== 4'b0010 || data_out !== exp_dout) begin
      n_fail++;
      $display("FAIL txn_after: busy=%b done=%b cs_n=%b ad_oe=%b data_out=%h expected 0 0 1 0 %h",
               busy, done, cs_n, ad_oe, data_out, exp_dout);
    end
    next_cycle;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs;
    ad_in = 8'($urandom);
    next_cycle;
    next_cycle;
    reset = 1'b0;
    exp_dout = 8'h00;
    @(negedge clk);
    n_tests++;
    if ({ad_out, ad_oe, cs_n, a_d, wr_n, rd_n, data_out, busy, done} !== {8'h00, 5'b01011, 8'h00, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: ad_out=%h oe=%b cs_n=%b a_d=%b wr_n=%b rd_n=%b dout=%h busy=%b done=%b",
               ad_out, ad_oe, cs_n, a_d, wr_n, rd_n, data_out, busy, done);
    end
    next_cycle;
  endtask

  task automatic test_directed;
    run_txn(1'b1, 1'b0, 8'h21, 8'h59, 8'h00, 0);
    run_txn(1'b0, 1'b0, 8'hF0, 8'h00, 8'h37, 0);
    n_tests++;
    if (data_out !== 8'h37) begin
      n_fail++;
      $display("FAIL read_f0: data_out got %h expected 37", data_out);
    end
  endtask

  task automatic test_ignored;
    for (int i = 0; i < 2; i++) begin
      act_rtc   = 1'b0;
      wr_strobe = (i == 0);
      rd_strobe = (i == 1);
      dir       = 8'h21;
      next_cycle;
      idle_inputs;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_tests++;
        if ({busy, cs_n, ad_oe, done} !== 4'b0100) begin
          n_fail++;
          $display("FAIL no_act_rtc: busy=%b cs_n=%b ad_oe=%b done=%b expected 0 1 0 0",
                   busy, cs_n, ad_oe, done);
        end
        next_cycle;
      end
    end
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 1'b0, 8'h10, 8'hA5, 8'h00, 4);
    run_txn(1'b0, 1'b0, 8'h33, 8'h00, 8'h6C, 3);
    run_txn(1'b1, 1'b1, 8'h55, 8'h3C, 8'h00, 0);
  endtask

  task automatic test_reset_mid;
    act_rtc = 1'b1; wr_strobe = 1'b1; rd_strobe = 1'b0;
    dir = 8'h24; data_in = 8'h12;
    next_cycle;
    idle_inputs;
    repeat (4) next_cycle;
    reset = 1'b1;
    next_cycle;
    reset = 1'b0;
    exp_dout = 8'h00;
    for (int c = 0; c < 5 * P + 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({cs_n, ad_oe, busy, done} !== 4'b1000 || data_out !== exp_dout) begin
        n_fail++;
        $display("FAIL reset_abort +%0d: cs_n=%b ad_oe=%b busy=%b done=%b dout=%h", c, cs_n, ad_oe, busy, done, data_out);
      end
      next_cycle;
    end
    run_txn(1'b1, 1'b0, 8'h24, 8'h12, 8'h00, 0);
  endtask

  task automatic test_random;
    logic [7:0] a;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 8'(8'h20 + $urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 1) == 0) a = 8'(8'h40 + $urandom_range(0, 4));
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom), 8'($urandom), 0);
    end
  endtask

  task automatic test_bcd;
`ifdef RTC_BCD_CONV_EN
    run_txn(1'b1, 1'b0, 8'h22, 8'd45, 8'h00, 0);
    run_txn(1'b1, 1'b0, 8'h23, 8'd150, 8'h00, 0);
    run_txn(1'b0, 1'b0, 8'h41, 8'h00, 8'h45, 0);
    n_tests++;
    if (data_out !== 8'd45) begin
      n_fail++;
      $display("FAIL bcd_read_41: data_out got %h expected %h", data_out, 8'd45);
    end
    run_txn(1'b0, 1'b0, 8'h02, 8'h00, 8'h45, 0);
    n_tests++;
    if (data_out !== 8'h45) begin
      n_fail++;
      $display("FAIL bcd_read_02: data_out got %h expected 45", data_out);
    end
`else
    run_txn(1'b1, 1'b0, 8'h22, 8'd45, 8'h00, 0);
    run_txn(1'b0, 1'b0, 8'h41, 8'h00, 8'h45, 0);
    n_tests++;
    if (data_out !== 8'h45) begin
      n_fail++;
      $display("FAIL raw_read_41: data_out got %h expected 45", data_out);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs;
    ad_in = 8'h00;
    test_reset;
    test_directed;
    test_ignored;
    test_back_to_back;
    test_reset_mid;
    test_bcd;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
